// File: rtl/scope_trigger_capture.sv
// -----------------------------------------------------------------------------
// scope_trigger_capture
//
// Front end of the waveform display. Decimates the raw sample stream by a
// runtime factor, looks for a level/edge trigger with hysteresis, then emits
// one frame of CAPTURE_LEN decimated samples as single-cycle strobes followed
// by a holdoff of HOLDOFF_LEN discarded decimated samples. If no trigger is
// seen within AUTO_TIMEOUT decimated samples a frame is forced.
//
// Optional build macro: SCOPE_PEAK_DECIM_EN
//   defined   -> each group's result is the sample of largest magnitude
//                (earliest wins ties, magnitude in DATA_W+1 bits)
//   undefined -> each group's result is the sample that completes the group
//
// Ports:
//   i_clk           system clock
//   i_rst_n         synchronous active-low reset
//   i_sample_valid  input sample strobe (back-to-back allowed)
//   i_sample        signed input sample
//   i_decim         decimation factor N (0 behaves as 1)
//   i_trig_level    signed trigger level
//   i_trig_falling  0 = rising-edge trigger, 1 = falling-edge trigger
//   i_run           0 = stay in holdoff once the current frame completes
//   o_sample_valid  one-cycle strobe per emitted sample
//   o_audio_data    emitted sample, held between strobes
//   o_state         00 WAIT_TRIG, 01 CAPTURE, 10 HOLDOFF
//   o_triggered     1 = frame started on a real trigger, 0 = auto-timeout
// -----------------------------------------------------------------------------
module scope_trigger_capture #(
    parameter int DATA_W       = 16,
    parameter int CAPTURE_LEN  = 560,
    parameter int HOLDOFF_LEN  = 140,
    parameter int AUTO_TIMEOUT = 4096,
    parameter int HYST         = 256
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_sample_valid,
    input  logic [DATA_W-1:0] i_sample,
    input  logic [7:0]        i_decim,
    input  logic [DATA_W-1:0] i_trig_level,
    input  logic              i_trig_falling,
    input  logic              i_run,
    output logic              o_sample_valid,
    output logic [DATA_W-1:0] o_audio_data,
    output logic [1:0]        o_state,
    output logic              o_triggered
);
    localparam int EW   = DATA_W + 2;
    localparam int FR_W = $clog2(CAPTURE_LEN + 1);
    localparam int HO_W = $clog2(HOLDOFF_LEN + 1);
    localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [FR_W-1:0]      FR_LAST = FR_W'(CAPTURE_LEN - 1);
    localparam logic [HO_W-1:0]      HO_LAST = HO_W'(HOLDOFF_LEN - 1);
    localparam logic [HO_W-1:0]      HO_FULL = HO_W'(HOLDOFF_LEN);
    localparam logic [TO_W-1:0]      TO_LAST = TO_W'(AUTO_TIMEOUT - 1);
    localparam logic signed [EW-1:0] HYST_E  = EW'(HYST);

    typedef enum logic [1:0] {
        ST_WAIT = 2'b00,
        ST_CAPT = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d, n_eff_s;
    logic              grp_done_s;
    logic [DATA_W-1:0] grp_res_s;
    logic              dec_vld_q;
    logic [DATA_W-1:0] dec_dat_q, dec_dat_d;
    logic              arm_q, arm_d;
    logic [TO_W-1:0]   tmo_q, tmo_d;
    logic [FR_W-1:0]   fr_q, fr_d;
    logic [HO_W-1:0]   ho_q, ho_d;
    logic              trig_q, trig_d;
    logic              ovld_q, ovld_d;
    logic [DATA_W-1:0] odat_q, odat_d;
    logic signed [EW-1:0] x_e_s, lvl_e_s;
    logic              arm_set_s, fire_s;

    // Group counter; ">=" lets a lowered i_decim close an oversized group at once
    always_comb begin
        n_eff_s    = (i_decim == 8'd0) ? 8'd1 : i_decim;
        cnt_d      = cnt_q;
        grp_done_s = 1'b0;
        if (i_sample_valid) begin
            if (cnt_q >= (n_eff_s - 8'd1)) begin
                grp_done_s = 1'b1;
                cnt_d      = 8'd0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end else begin
            cnt_d = cnt_q;
        end
        if (grp_done_s) begin
            dec_dat_d = grp_res_s;
        end else begin
            dec_dat_d = dec_dat_q;
        end
    end

`ifdef SCOPE_PEAK_DECIM_EN
    logic [DATA_W-1:0] pk_q, pk_d;
    logic [DATA_W:0]   pk_abs_q, pk_abs_d, smp_abs_s, grp_abs_s;

    // Magnitude in DATA_W+1 bits so the most negative code ranks highest
    function automatic logic [DATA_W:0] abs_f(input logic [DATA_W-1:0] v);
        logic [DATA_W:0] ext;
        ext = {v[DATA_W-1], v};
        if (v[DATA_W-1]) begin
            abs_f = (~ext) + {{DATA_W{1'b0}}, 1'b1};
        end else begin
            abs_f = ext;
        end
    endfunction

    // Running peak of the group; strict ">" keeps the earliest sample on ties
    always_comb begin
        smp_abs_s = abs_f(i_sample);
        if ((cnt_q == 8'd0) || (smp_abs_s > pk_abs_q)) begin
            grp_res_s = i_sample;
            grp_abs_s = smp_abs_s;
        end else begin
            grp_res_s = pk_q;
            grp_abs_s = pk_abs_q;
        end
        if (i_sample_valid) begin
            pk_d     = grp_res_s;
            pk_abs_d = grp_abs_s;
        end else begin
            pk_d     = pk_q;
            pk_abs_d = pk_abs_q;
        end
    end

    // Peak registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pk_q     <= {DATA_W{1'b0}};
            pk_abs_q <= {(DATA_W+1){1'b0}};
        end else begin
            pk_q     <= pk_d;
            pk_abs_q <= pk_abs_d;
        end
    end
`else
    // Group result is simply the completing sample
    always_comb begin
        grp_res_s = i_sample;
    end
`endif

    // Trigger detection on the decimated sample, sign-extended so level+-HYST cannot wrap
    always_comb begin
        x_e_s   = {{2{dec_dat_q[DATA_W-1]}}, dec_dat_q};
        lvl_e_s = {{2{i_trig_level[DATA_W-1]}}, i_trig_level};
        if (i_trig_falling) begin
            arm_set_s = (x_e_s > (lvl_e_s + HYST_E));
            fire_s    = arm_q && (x_e_s <= lvl_e_s);
        end else begin
            arm_set_s = (x_e_s < (lvl_e_s - HYST_E));
            fire_s    = arm_q && (x_e_s >= lvl_e_s);
        end
    end

    // Frame state machine; everything advances only on a decimated strobe
    always_comb begin
        state_d = state_q;
        arm_d   = arm_q;
        tmo_d   = tmo_q;
        fr_d    = fr_q;
        ho_d    = ho_q;
        trig_d  = trig_q;
        ovld_d  = 1'b0;
        odat_d  = odat_q;
        if (dec_vld_q) begin
            case (state_q)
                ST_WAIT: begin
                    if (fire_s) begin
                        state_d = ST_CAPT;
                        trig_d  = 1'b1;
                        arm_d   = 1'b0;
                        ovld_d  = 1'b1;
                        odat_d  = dec_dat_q;
                        fr_d    = FR_W'(1);
                    end else if (tmo_q >= TO_LAST) begin
                        state_d = ST_CAPT;
                        trig_d  = 1'b0;
                        ovld_d  = 1'b1;
                        odat_d  = dec_dat_q;
                        fr_d    = FR_W'(1);
                    end else begin
                        tmo_d = tmo_q + TO_W'(1);
                        if (arm_set_s) begin
                            arm_d = 1'b1;
                        end else begin
                            arm_d = arm_q;
                        end
                    end
                end
                ST_CAPT: begin
                    ovld_d = 1'b1;
                    odat_d = dec_dat_q;
                    if (fr_q >= FR_LAST) begin
                        state_d = ST_HOLD;
                        fr_d    = {FR_W{1'b0}};
                        ho_d    = {HO_W{1'b0}};
                    end else begin
                        fr_d = fr_q + FR_W'(1);
                    end
                end
                ST_HOLD: begin
                    // Count saturates so a late i_run still leaves on the next strobe
                    if (ho_q < HO_FULL) begin
                        ho_d = ho_q + HO_W'(1);
                    end else begin
                        ho_d = ho_q;
                    end
                    if ((ho_q >= HO_LAST) && i_run) begin
                        state_d = ST_WAIT;
                        tmo_d   = {TO_W{1'b0}};
                        arm_d   = 1'b0;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    state_d = ST_WAIT;
                    arm_d   = 1'b0;
                    tmo_d   = {TO_W{1'b0}};
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State, counters, decimator pipeline and output registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= ST_WAIT;
            cnt_q     <= 8'd0;
            dec_vld_q <= 1'b0;
            dec_dat_q <= {DATA_W{1'b0}};
            arm_q     <= 1'b0;
            tmo_q     <= {TO_W{1'b0}};
            fr_q      <= {FR_W{1'b0}};
            ho_q      <= {HO_W{1'b0}};
            trig_q    <= 1'b0;
            ovld_q    <= 1'b0;
            odat_q    <= {DATA_W{1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dec_vld_q <= grp_done_s;
            dec_dat_q <= dec_dat_d;
            arm_q     <= arm_d;
            tmo_q     <= tmo_d;
            fr_q      <= fr_d;
            ho_q      <= ho_d;
            trig_q    <= trig_d;
            ovld_q    <= ovld_d;
            odat_q    <= odat_d;
        end
    end

    assign o_sample_valid = ovld_q;
    assign o_audio_data   = odat_q;
    assign o_state        = state_q;
    assign o_triggered    = trig_q;

endmodule

// File: tb/tb_scope_trigger_capture.sv
module tb_scope_trigger_capture;
    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_sample_valid = 1'b0;
    logic [15:0] i_sample = 16'd0;
    logic [7:0]  i_decim = 8'd1;
    logic [15:0] i_trig_level = 16'd0;
    logic        i_trig_falling = 1'b0;
    logic        i_run = 1'b1;
    logic        o_sample_valid;
    logic [15:0] o_audio_data;
    logic [1:0]  o_state;
    logic        o_triggered;

    typedef struct {
        logic [15:0] data;
        logic        trig;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int strobes = 0;

    scope_trigger_capture dut (
        .i_clk          (clk),
        .i_rst_n        (i_rst_n),
        .i_sample_valid (i_sample_valid),
        .i_sample       (i_sample),
        .i_decim        (i_decim),
        .i_trig_level   (i_trig_level),
        .i_trig_falling (i_trig_falling),
        .i_run          (i_run),
        .o_sample_valid (o_sample_valid),
        .o_audio_data   (o_audio_data),
        .o_state        (o_state),
        .o_triggered    (o_triggered)
    );

    always #5 clk = ~clk;

    // Cycle counter, advanced on each active edge
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard: every strobe must match the oldest expected entry
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (o_sample_valid === 1'b1) begin
            strobes++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got data %0d at cycle %0d, required no strobe",
                         $signed(o_audio_data), cyc);
            end else begin
                e = sb.pop_front();
                if (o_audio_data !== e.data) begin
                    errors++;
                    $display("FAIL strobe_data: got %0d, required %0d", $signed(o_audio_data), $signed(e.data));
                end
                checks++;
                if (o_triggered !== e.trig) begin
                    errors++;
                    $display("FAIL strobe_triggered: got %0b, required %0b", o_triggered, e.trig);
                end
                checks++;
                if (cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL strobe_timing: got cycle %0d, required cycle %0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic send(input int v);
        i_sample_valid = 1'b1;
        i_sample       = 16'(v);
        @(posedge clk);
        #1;
        i_sample_valid = 1'b0;
    endtask

    // Expect a strobe 2 cycles after the valid just sent
    task automatic push(input int v, input logic trig);
        exp_t e;
        e.data = 16'(v);
        e.trig = trig;
        e.cyc  = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        i_rst_n        = 1'b0;
        i_sample_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (o_sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b, required 0", o_sample_valid); end
        checks++;
        if (o_audio_data !== 16'd0) begin errors++; $display("FAIL reset_data: got %0d, required 0", o_audio_data); end
        checks++;
        if (o_state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b, required 00", o_state); end
        checks++;
        if (o_triggered !== 1'b0) begin errors++; $display("FAIL reset_triggered: got %0b, required 0", o_triggered); end
        i_rst_n = 1'b1;
    endtask

    function automatic int tri_wave(input int i, input int a, input int s);
        int p;
        p = (i * s) % (4 * a);
        if (p < a) return p;
        else if (p < 3 * a) return 2 * a - p;
        else return p - 4 * a;
    endfunction

    task automatic test_reset();
        i_decim = 8'd1; i_trig_falling = 1'b0; i_trig_level = 16'd0; i_run = 1'b1;
        apply_reset();
        idle(5);
        checks++;
        if (o_state !== 2'b00) begin errors++; $display("FAIL idle_state: got %b, required 00", o_state); end
    endtask

    task automatic test_ramp_trigger();
        int s0;
        i_decim = 8'd1; i_trig_falling = 1'b0; i_trig_level = 16'd0; i_run = 1'b1;
        apply_reset();
        s0 = strobes;
        for (int v = -1000; v <= 1000; v++) begin
            send(v);
            if (v >= 0 && v < 560) push(v, 1'b1);
            if (v == 560 || v == 699) begin
                checks++;
                if (o_state !== 2'b10) begin errors++; $display("FAIL ramp_holdoff_state at %0d: got %b, required 10", v, o_state); end
            end
            if (v == 700) begin
                checks++;
                if (o_state !== 2'b00) begin errors++; $display("FAIL ramp_rearm_state: got %b, required 00", o_state); end
            end
        end
        idle(4);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL ramp_missing: got %0d pending, required 0", sb.size()); end
        sb.delete();
        checks++;
        if (strobes - s0 != 560) begin errors++; $display("FAIL ramp_count: got %0d strobes, required 560", strobes - s0); end
    endtask

    task automatic test_decim();
        i_decim = 8'd4; i_trig_falling = 1'b0; i_trig_level = 16'd0; i_run = 1'b1;
        apply_reset();
        repeat (4) send(-1000);
        for (int k = 0; k < 80; k++) begin
            send(k);
            if (k % 4 == 3) push(k, 1'b1);
        end
        idle(1);
        send(80); send(81); send(82);
        i_decim = 8'd2;              // group already holds 3 samples
        send(83); push(83, 1'b1);
        send(84);
        send(85); push(85, 1'b1);
        i_decim = 8'd0;              // behaves as 1
        send(86); push(86, 1'b1);
        idle(2);
        send(87); push(87, 1'b1);
        idle(4);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL decim_missing: got %0d pending, required 0", sb.size()); end
        sb.delete();
    endtask

    task automatic test_auto_timeout();
        i_decim = 8'd1; i_trig_falling = 1'b0; i_trig_level = 16'd1000; i_run = 1'b1;
        apply_reset();
        for (int i = 0; i < 4660; i++) begin
            send(500);
            if (i >= 4095 && i < 4655) push(500, 1'b0);
            if (i == 4095) begin
                checks++;
                if (o_state !== 2'b00) begin errors++; $display("FAIL timeout_early_state: got %b, required 00", o_state); end
            end
            if (i == 4096) begin
                checks++;
                if (o_state !== 2'b01) begin errors++; $display("FAIL timeout_state: got %b, required 01", o_state); end
                checks++;
                if (o_triggered !== 1'b0) begin errors++; $display("FAIL timeout_triggered: got %0b, required 0", o_triggered); end
            end
        end
        idle(4);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL timeout_missing: got %0d pending, required 0", sb.size()); end
        sb.delete();
        checks++;
        if (o_state !== 2'b10) begin errors++; $display("FAIL timeout_end_state: got %b, required 10", o_state); end
    endtask

    task automatic test_falling_hyst();
        int v;
        int start;
        bit seen_hi;
        i_decim = 8'd1; i_trig_falling = 1'b1; i_trig_level = 16'd0; i_run = 1'b1;
        // Small wave stays inside the hysteresis band: only the timeout can start a frame
        apply_reset();
        for (int i = 0; i < 4660; i++) begin
            v = tri_wave(i, 100, 5);
            send(v);
            if (i >= 4095 && i < 4655) push(v, 1'b0);
            if (i == 4000) begin
                checks++;
                if (o_state !== 2'b00) begin errors++; $display("FAIL small_wave_state: got %b, required 00", o_state); end
            end
        end
        idle(4);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL small_wave_missing: got %0d pending, required 0", sb.size()); end
        sb.delete();
        // Large wave: frame starts at first sample <= 0 after one above +256
        apply_reset();
        start = -1;
        seen_hi = 1'b0;
        for (int i = 0; i < 800; i++) begin
            v = tri_wave(i, 2000, 50);
            send(v);
            if (start < 0) begin
                if (seen_hi && v <= 0) start = i;
                else if (v > 256) seen_hi = 1'b1;
            end
            if (start >= 0 && i < start + 560) push(v, 1'b1);
        end
        idle(4);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL big_wave_missing: got %0d pending, required 0", sb.size()); end
        sb.delete();
    endtask

    task automatic test_run_hold();
        int v;
        i_decim = 8'd1; i_trig_falling = 1'b0; i_trig_level = 16'd0; i_run = 1'b1;
        apply_reset();
        for (int i = 0; i < 1260; i++) begin
            v = i - 300;
            send(v);
            if (v >= 0 && v < 560) push(v, 1'b1);
            if (v == 10) i_run = 1'b0;
        end
        idle(4);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL run_missing: got %0d pending, required 0", sb.size()); end
        sb.delete();
        checks++;
        if (o_state !== 2'b10) begin errors++; $display("FAIL run_hold_state: got %b, required 10", o_state); end
        i_run = 1'b1;
        send(960);
        checks++;
        if (o_state !== 2'b10) begin errors++; $display("FAIL run_resume_early: got %b, required 10", o_state); end
        send(961);
        checks++;
        if (o_state !== 2'b00) begin errors++; $display("FAIL run_resume_state: got %b, required 00", o_state); end
    endtask

    task automatic test_peak_and_midframe_reset();
        i_decim = 8'd4; i_trig_falling = 1'b1; i_trig_level = 16'd10; i_run = 1'b1;
        apply_reset();
        repeat (4) send(1000);
        send(10); send(-32768); send(32767); send(5);
`ifdef SCOPE_PEAK_DECIM_EN
        push(-32768, 1'b1);
`else
        push(5, 1'b1);
`endif
        send(-7); send(7); send(3); send(1);
`ifdef SCOPE_PEAK_DECIM_EN
        push(-7, 1'b1);
`else
        push(1, 1'b1);
`endif
        idle(3);
        // Group completes, then reset lands while its strobe is in flight
        send(20); send(20); send(20); send(20);
        apply_reset();
        repeat (16) send(0);
        idle(4);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL peak_missing: got %0d pending, required 0", sb.size()); end
        sb.delete();
        checks++;
        if (o_state !== 2'b00) begin errors++; $display("FAIL post_reset_state: got %b, required 00", o_state); end
    endtask

    initial begin
        test_reset();
        test_ramp_trigger();
        test_decim();
        test_auto_timeout();
        test_falling_hyst();
        test_run_hold();
        test_peak_and_midframe_reset();
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/scope_trigger_capture.md
Name: scope_trigger_capture

Overview:
- Upstream stage of the waveform display. Takes the raw audio sample stream, decimates it by a runtime factor, and finds a trigger point with a level/edge detector plus hysteresis.
- Emits one frame of CAPTURE_LEN decimated samples as single-cycle valid strobes, then holds off. The display therefore redraws a stable, triggered waveform instead of a free-running scroll.
- Its outputs drive the display's sample-valid and audio-data inputs directly.

Parameters:
- DATA_W, 16, sample width (signed two's complement).
- CAPTURE_LEN, 560, decimated samples emitted per frame (equals display width).
- HOLDOFF_LEN, 140, decimated samples discarded after each frame.
- AUTO_TIMEOUT, 4096, decimated samples waited for a trigger before forcing capture.
- HYST, 256, trigger hysteresis in LSBs.

Ports:
- i_clk, in, 1, single system clock.
- i_rst_n, in, 1, reset.
- i_sample_valid, in, 1, input sample strobe; back-to-back cycles allowed.
- i_sample, in, DATA_W, signed audio sample.
- i_decim, in, 8, decimation factor N; 0 treated as 1.
- i_trig_level, in, DATA_W, signed trigger level.
- i_trig_falling, in, 1, 0 = rising-edge trigger, 1 = falling-edge trigger.
- i_run, in, 1, 0 = freeze after the current frame completes.
- o_sample_valid, out, 1, one-cycle strobe per emitted sample.
- o_audio_data, out, DATA_W, emitted sample; held between strobes.
- o_state, out, 2, 00 WAIT_TRIG, 01 CAPTURE, 10 HOLDOFF.
- o_triggered, out, 1, 1 = current/last frame started on a real trigger, 0 = auto-timeout.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-low, named i_rst_n alongside clock i_clk.
  - On reset: all outputs 0, state WAIT_TRIG, arm flag 0, all counters 0.
  - Reset mid-frame abandons the frame; no further strobes until a new trigger.
- Decimator:
  - Group counter counts accepted i_sample_valid cycles 0..N-1.
  - The group completes on the valid where count == N-1, or where count >= N-1 after i_decim was lowered. Count then returns to 0.
  - Group result = the completing sample (unless the optional feature is enabled).
  - The result is registered as an internal decimated strobe d one cycle later.
- Trigger (evaluated on each d, arithmetic in DATA_W+2 bits, no overflow):
  - Rising: arm sets when x < level-HYST; the trigger fires when armed and x >= level. The arm flag clears on fire.
  - Falling: mirrored, using x > level+HYST and x <= level.
  - Arm flag clears on entry to WAIT_TRIG.
- State machine (advances only on d):
  - WAIT_TRIG:
    - Timeout counter increments on each d.
    - If the trigger fires on d: go to CAPTURE, o_triggered=1, and that sample is frame sample 0.
    - Else if the timeout counter reaches AUTO_TIMEOUT-1: go to CAPTURE, o_triggered=0, and the current sample is frame sample 0.
    - If both occur on the same d, the trigger wins.
  - CAPTURE:
    - Every d is emitted.
    - After the CAPTURE_LEN-th emission: go to HOLDOFF and clear the frame counter.
  - HOLDOFF:
    - Decimated samples are discarded and counted.
    - When the count reaches HOLDOFF_LEN and i_run=1: go to WAIT_TRIG and clear the timeout counter.
    - While i_run=0: remain in HOLDOFF indefinitely with no strobes.
- Output:
  - o_sample_valid asserts exactly 2 cycles after the i_sample_valid that completes the group, for 1 cycle.
  - o_audio_data updates in that same cycle.
  - Never more than one strobe per completed group.
- i_decim and i_trig_* may change at any time; new values take effect from the next group or d.

Optional Feature:
- Macro: SCOPE_PEAK_DECIM_EN.
- Defined: the group result is the sample with the largest absolute value in the group. The earliest sample wins ties. Absolute value is computed in DATA_W+1 bits, so -32768 ranks above 32767. Latency is unchanged.
- Undefined: the group result is the completing sample; no peak registers are built.

Test Plan:
- Reset with i_decim=1 and rising trigger at level 0; feed ramp -1000..+1000 step 1 -> first strobe carries 0 with o_triggered=1. Exactly 560 strobes follow with consecutive values 0..559, then o_state=10.
- i_decim=4, valid on consecutive cycles, samples 0,1,2,... -> strobes carry 3,7,11,... Each strobe occurs 2 cycles after the valid of sample 3,7,11.
- Constant input 500, trigger level 1000 -> no trigger. After 4096 decimated samples o_state=01 with o_triggered=0, and 560 strobes of value 500.
- Falling trigger at level 0, sine amplitude 100 (inside HYST) -> never arms; auto-trigger only. Amplitude 2000 -> the frame starts at the first sample <= 0 after a sample > 256.
- i_run=0 during CAPTURE -> frame completes all 560 strobes, state stays 10 indefinitely. Raising i_run -> WAIT_TRIG after the holdoff count is satisfied.
- With SCOPE_PEAK_DECIM_EN and i_decim=4, group {10,-32768,32767,5} -> strobe value -32768. Separately: assert i_rst_n=0 mid-frame -> all outputs 0 on the next edge and no partial-frame strobes.
